multicycle_control_fsm: RTL

// - Main control state machine for the multicycle MIPS datapath (shared memory, IR, A/B/ALUOut regs).
// - Sequences FETCH/DECODE/execute states per instruction, driving every datapath mux select and write enable.
// - Supports R-type, LW, SW, BEQ and J. Sits between the instruction register opcode field and the datapath.
// - The ALU control decoder consumes ALUOp plus funct; this block does not decode funct.

---
 rtl/multicycle_control_fsm_if.sv | 48 ++++
 rtl/multicycle_control_fsm.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm_if.sv
// Bundle between the multicycle control FSM and the MIPS datapath.
//   master : the control FSM (consumes opcode/mem_ready, drives controls + debug)
//   slave  : the datapath side (drives opcode/mem_ready, consumes controls)
// Signals:
//   opcode[5:0]   IR[31:26]
//   mem_ready     memory access done (only honoured with MEM_WAIT_EN)
//   IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegDst, RegWrite, ALUSrcA,
//   ALUSrcB[1:0], ALUOp[1:0], PCSource[1:0], PCWrite, PCWriteCond : datapath controls
//   state[3:0]    current FSM state (debug)
//   illegal       unsupported opcode seen in DECODE
//   instr_count   completed-instruction counter
// Handshake: there is no valid/ready pair on this bundle. The only flow
// control is mem_ready, which (with MEM_WAIT_EN) holds FETCH/MEMRD/MEMWR
// until it is sampled high on a rising clk edge.
interface multicycle_control_fsm_if;
  logic [5:0]  opcode;
  logic        mem_ready;
  logic        IorD;
  logic        MemRead;
  logic        MemWrite;
  logic        MemtoReg;
  logic        IRWrite;
  logic        RegDst;
  logic        RegWrite;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ALUOp;
  logic [1:0]  PCSource;
  logic        PCWrite;
  logic        PCWriteCond;
  logic [3:0]  state;
  logic        illegal;
  logic [31:0] instr_count;

  modport master (
    input  opcode, mem_ready,
    output IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegDst, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, PCSource, PCWrite, PCWriteCond,
           state, illegal, instr_count
  );

  modport slave (
    output opcode, mem_ready,
    input  IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegDst, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, PCSource, PCWrite, PCWriteCond,
           state, illegal, instr_count
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multicycle MIPS datapath (R-type, LW, SW, BEQ, J).
// Moore outputs decoded from the state register drive every datapath mux
// select and write enable; ALUOp is passed on to the ALU control decoder.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    multicycle_control_fsm_if.master (opcode, mem_ready, controls,
//          state debug, illegal, instr_count)
// Optional build macro: MEM_WAIT_EN -- FETCH, MEMRD and MEMWR stall while
// mem_ready=0. Without it mem_ready is ignored and every state lasts 1 cycle.
module multicycle_control_fsm (
  input logic                  clk,
  input logic                  reset,
  multicycle_control_fsm_if.master bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_RWB    = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_JUMP   = 4'd9;

  logic [3:0]  state_q;
  logic [3:0]  state_d;
  logic [5:0]  op_q;
  logic [31:0] count_q;
  logic        mem_ok;
  logic        done;
  logic        op_legal;

`ifdef MEM_WAIT_EN
  assign mem_ok = bus.mem_ready;
`else
  assign mem_ok = 1'b1;
  logic unused_mem_ready;
  assign unused_mem_ready = bus.mem_ready;
`endif

  assign op_legal = (bus.opcode == OP_RTYPE) || (bus.opcode == OP_LW) ||
                    (bus.opcode == OP_SW)    || (bus.opcode == OP_BEQ) ||
                    (bus.opcode == OP_J);

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ok ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      // Only LW or SW can reach MEMADR, so anything but LW is a store.
      S_MEMADR: state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = mem_ok ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = mem_ok ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_RWB;
      S_RWB:    state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // An instruction completes on the edge that leaves its final state.
  always_comb begin
    done = 1'b0;
    case (state_q)
      S_MEMWB, S_RWB, S_BRANCH, S_JUMP: done = 1'b1;
      S_MEMWR:                          done = mem_ok;
      default:                          done = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      op_q    <= 6'd0;
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) op_q <= bus.opcode;
      if (done) count_q <= count_q + 32'd1;
    end
  end

  always_comb begin
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.MemtoReg    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.RegDst      = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.ALUSrcB     = 2'b00;
    bus.ALUOp       = 2'b00;
    bus.PCSource    = 2'b00;
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.illegal     = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.MemRead = 1'b1;
        // IR and PC load only once the fetched word is actually present.
        bus.IRWrite = mem_ok;
        bus.PCWrite = mem_ok;
        bus.ALUSrcB = 2'b01;
      end
      S_DECODE: begin
        bus.ALUSrcB = 2'b11;
        bus.illegal = !op_legal;
      end
      S_MEMADR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
      end
      S_MEMWB: begin
        bus.RegWrite = 1'b1;
        bus.MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        bus.MemWrite = 1'b1;
        bus.IorD     = 1'b1;
      end
      S_EXEC: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = 2'b10;
      end
      S_RWB: begin
        bus.RegDst   = 1'b1;
        bus.RegWrite = 1'b1;
      end
      S_BRANCH: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALUOp       = 2'b01;
        bus.PCWriteCond = 1'b1;
        bus.PCSource    = 2'b01;
      end
      S_JUMP: begin
        bus.PCWrite  = 1'b1;
        bus.PCSource = 2'b10;
      end
      default: ;
    endcase
    // Any state-changing strobe is suppressed while reset is held so an
    // abandoned instruction cannot write anything.
    if (reset) begin
      bus.PCWrite     = 1'b0;
      bus.PCWriteCond = 1'b0;
      bus.IRWrite     = 1'b0;
      bus.MemRead     = 1'b0;
      bus.MemWrite    = 1'b0;
      bus.RegWrite    = 1'b0;
      bus.illegal     = 1'b0;
    end
  end

  assign bus.state       = state_q;
  assign bus.instr_count = count_q;

endmodule
